// File: rtl/alu_result_packer_if.sv
// Bus bundle between the ALU result side, the packer and the UART TX byte consumer.
// The packer sits on the slave modport; the master modport is the ALU/TX environment.
interface alu_result_packer_if #(
   parameter int RESULT_WIDTH = 16
);
   logic [RESULT_WIDTH-1:0] ALU_OUT;
   logic                    OUT_VALID;
   logic                    TX_READY;
   logic [7:0]              TX_DATA;
   logic                    TX_VALID;
   logic                    BUSY;
   logic                    FIFO_FULL;
   logic                    OVERFLOW;

   modport master (
      output ALU_OUT, OUT_VALID, TX_READY,
      input  TX_DATA, TX_VALID, BUSY, FIFO_FULL, OVERFLOW
   );

   modport slave (
      input  ALU_OUT, OUT_VALID, TX_READY,
      output TX_DATA, TX_VALID, BUSY, FIFO_FULL, OVERFLOW
   );
endinterface

// File: rtl/alu_result_packer.sv
// Buffers ALU results in a small FIFO and streams them out LSB byte first on a valid/ready port.
// Define RESULT_CHECKSUM_EN to append an XOR checksum byte after each result.
module alu_result_packer #(
   parameter int RESULT_WIDTH = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input logic              CLK,
   input logic              RST,
   alu_result_packer_if.slave bus
);
   localparam int NBYTES = RESULT_WIDTH / 8;
`ifdef RESULT_CHECKSUM_EN
   localparam int NSEND  = NBYTES + 1;
`else
   localparam int NSEND  = NBYTES;
`endif
   localparam int SR_W   = NSEND * 8;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
   localparam int IDX_W  = (NSEND > 1) ? $clog2(NSEND) : 1;

   typedef enum logic {IDLE, SEND} state_e;

   logic [RESULT_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]        wrPtr_q, rdPtr_q;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    full_q;
   logic                    overflow_q;
   state_e                  state_q;
   logic [IDX_W-1:0]        idx_q;
   logic [SR_W-1:0]         sr_q;
   logic                    txValid_q;

   logic                    handshake;
   logic                    lastByte;
   logic                    pop;
   logic                    push;
   logic [SR_W-1:0]         headPacked;

   // The shift register holds the data bytes with the optional checksum appended on top,
   // so every transmitted byte is simply the low byte of the register.
   function automatic logic [SR_W-1:0] packResult(input logic [RESULT_WIDTH-1:0] data);
`ifdef RESULT_CHECKSUM_EN
      logic [7:0] csum;
      csum = '0;
      for (int b = 0; b < NBYTES; b++) begin
         csum = csum ^ data[8*b +: 8];
      end
      return {csum, data};
`else
      return data;
`endif
   endfunction

   always_comb begin
      handshake  = txValid_q && bus.TX_READY;
      lastByte   = (idx_q == IDX_W'(NSEND - 1));
      pop        = (count_q != '0) && ((state_q == IDLE) || (handshake && lastByte));
      push       = bus.OUT_VALID && ((count_q != CNT_W'(FIFO_DEPTH)) || pop);
      headPacked = packResult(mem_q[rdPtr_q]);
      count_d    = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // FIFO bookkeeping and the transmit FSM share one clocked block so reset clears everything together.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         full_q     <= 1'b0;
         overflow_q <= 1'b0;
         state_q    <= IDLE;
         idx_q      <= '0;
         sr_q       <= '0;
         txValid_q  <= 1'b0;
      end else begin
         if (push) begin
            mem_q[wrPtr_q] <= bus.ALU_OUT;
            wrPtr_q        <= wrPtr_q + PTR_W'(1);
         end
         if (pop) begin
            rdPtr_q <= rdPtr_q + PTR_W'(1);
         end
         if (bus.OUT_VALID && !push) begin
            overflow_q <= 1'b1;
         end
         count_q <= count_d;
         full_q  <= (count_d == CNT_W'(FIFO_DEPTH));

         case (state_q)
            IDLE: begin
               if (pop) begin
                  sr_q      <= headPacked;
                  idx_q     <= '0;
                  state_q   <= SEND;
                  txValid_q <= 1'b1;
               end
            end
            SEND: begin
               if (handshake) begin
                  if (!lastByte) begin
                     sr_q  <= sr_q >> 8;
                     idx_q <= idx_q + IDX_W'(1);
                  end else if (pop) begin
                     sr_q  <= headPacked;
                     idx_q <= '0;
                  end else begin
                     sr_q      <= '0;
                     idx_q     <= '0;
                     state_q   <= IDLE;
                     txValid_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               txValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.TX_DATA   = sr_q[7:0];
   assign bus.TX_VALID  = txValid_q;
   assign bus.BUSY      = (count_q != '0) || (state_q == SEND);
   assign bus.FIFO_FULL = full_q;
   assign bus.OVERFLOW  = overflow_q;
endmodule

// File: tb/tb_alu_result_packer.sv
// Scoreboard bench for alu_result_packer: expected bytes are queued when results are driven
// and compared as the byte port handshakes. Honours RESULT_CHECKSUM_EN like the design.
module tb_alu_result_packer;
   localparam int RESULT_WIDTH = 16;
   localparam int FIFO_DEPTH   = 4;
   localparam int NBYTES       = RESULT_WIDTH / 8;
`ifdef RESULT_CHECKSUM_EN
   localparam int NSEND = NBYTES + 1;
`else
   localparam int NSEND = NBYTES;
`endif

   logic CLK;
   logic RST;
   int   checks;
   int   errors;
   logic [7:0] expQ[$];

   alu_result_packer_if #(.RESULT_WIDTH(RESULT_WIDTH)) bus ();

   alu_result_packer #(
      .RESULT_WIDTH(RESULT_WIDTH),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Queue the bytes a result should produce, including the checksum when enabled.
   task automatic expectResult(input logic [RESULT_WIDTH-1:0] data);
      logic [7:0] csum;
      csum = '0;
      for (int b = 0; b < NBYTES; b++) begin
         expQ.push_back(data[8*b +: 8]);
         csum = csum ^ data[8*b +: 8];
      end
`ifdef RESULT_CHECKSUM_EN
      expQ.push_back(csum);
`endif
   endtask

   // Drive one result-valid pulse; accepted results also go to the scoreboard.
   task automatic applyStimulus(input logic [RESULT_WIDTH-1:0] data, input bit accepted);
      bus.ALU_OUT   = data;
      bus.OUT_VALID = 1'b1;
      if (accepted) expectResult(data);
      tick();
      bus.OUT_VALID = 1'b0;
   endtask

   task automatic waitDrain(input string tag);
      int n;
      n = 0;
      while (n < 300 && !(expQ.size() == 0 && !bus.BUSY)) begin
         tick();
         n++;
      end
      checkOutput(tag, {31'd0, (expQ.size() == 0 && !bus.BUSY)}, 32'd1);
   endtask

   task automatic doReset();
      RST = 1'b1;
      bus.OUT_VALID = 1'b0;
      bus.TX_READY  = 1'b0;
      tick();
      RST = 1'b0;
      expQ.delete();
   endtask

   // Byte monitor: the handshake is decided at the next rising edge, so sample on the falling edge.
   always @(negedge CLK) begin
      if (!RST && bus.TX_VALID && bus.TX_READY) begin
         checkOutput("scoreboardHasByte", {31'd0, (expQ.size() != 0)}, 32'd1);
         if (expQ.size() != 0) begin
            checkOutput("txByte", {24'd0, bus.TX_DATA}, {24'd0, expQ.pop_front()});
         end
      end
   end

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int bubbles;
      checks = 0;
      errors = 0;
      RST = 1'b1;
      bus.ALU_OUT   = '0;
      bus.OUT_VALID = 1'b0;
      bus.TX_READY  = 1'b0;
      tick();
      tick();
      checkOutput("rstTxData",   {24'd0, bus.TX_DATA}, 32'd0);
      checkOutput("rstTxValid",  {31'd0, bus.TX_VALID}, 32'd0);
      checkOutput("rstBusy",     {31'd0, bus.BUSY}, 32'd0);
      checkOutput("rstFull",     {31'd0, bus.FIFO_FULL}, 32'd0);
      checkOutput("rstOverflow", {31'd0, bus.OVERFLOW}, 32'd0);
      RST = 1'b0;

      $display("[TB] single result latency");
      bus.TX_READY = 1'b1;
      applyStimulus(16'hA55A, 1'b1);
      checkOutput("latEdge1Valid", {31'd0, bus.TX_VALID}, 32'd0);
      checkOutput("latEdge1Busy",  {31'd0, bus.BUSY}, 32'd1);
      tick();
      checkOutput("latEdge2Valid", {31'd0, bus.TX_VALID}, 32'd1);
      checkOutput("latEdge2Byte0", {24'd0, bus.TX_DATA}, 32'h5A);
      for (int i = 0; i < NSEND; i++) tick();
      checkOutput("singleEndValid", {31'd0, bus.TX_VALID}, 32'd0);
      checkOutput("singleEndBusy",  {31'd0, bus.BUSY}, 32'd0);
      checkOutput("singleDrained",  expQ.size(), 32'd0);

      $display("[TB] back-pressure");
      bus.TX_READY = 1'b0;
      applyStimulus(16'h1234, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         checkOutput("bpValid", {31'd0, bus.TX_VALID}, 32'd1);
         checkOutput("bpHold",  {24'd0, bus.TX_DATA}, 32'h34);
         tick();
      end
      bus.TX_READY = 1'b1;
      waitDrain("bpDrain");

      $display("[TB] back-to-back");
      for (int i = 1; i <= 4; i++) applyStimulus(RESULT_WIDTH'(i), 1'b1);
      bubbles = 0;
      for (int n = 0; n < 60 && expQ.size() != 0; n++) begin
         if (!bus.TX_VALID) bubbles++;
         tick();
      end
      checkOutput("b2bBubbles", bubbles, 32'd0);
      waitDrain("b2bDrain");

      $display("[TB] overflow");
      bus.TX_READY = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(16'h0010 + 16'(i), 1'b1);
      checkOutput("ovfFullBefore", {31'd0, bus.FIFO_FULL}, 32'd1);
      checkOutput("ovfClearBefore", {31'd0, bus.OVERFLOW}, 32'd0);
      applyStimulus(16'h0015, 1'b0);
      checkOutput("ovfSet", {31'd0, bus.OVERFLOW}, 32'd1);
      bus.TX_READY = 1'b1;
      waitDrain("ovfDrain");
      checkOutput("ovfSticky", {31'd0, bus.OVERFLOW}, 32'd1);
      doReset();
      checkOutput("ovfClearedByReset", {31'd0, bus.OVERFLOW}, 32'd0);

      $display("[TB] push with pop at full");
      bus.TX_READY = 1'b0;
      for (int i = 0; i < 5; i++) applyStimulus(16'h0020 + 16'(i), 1'b1);
      checkOutput("simFull", {31'd0, bus.FIFO_FULL}, 32'd1);
      bus.TX_READY = 1'b1;
      for (int i = 0; i < NSEND - 1; i++) tick();
      checkOutput("simStillFull", {31'd0, bus.FIFO_FULL}, 32'd1);
      applyStimulus(16'hBEEF, 1'b1);
      checkOutput("simNoOverflow", {31'd0, bus.OVERFLOW}, 32'd0);
      checkOutput("simFullAfter",  {31'd0, bus.FIFO_FULL}, 32'd1);
      waitDrain("simDrain");
      checkOutput("simNoOverflowEnd", {31'd0, bus.OVERFLOW}, 32'd0);

      $display("[TB] reset mid-operation");
      bus.TX_READY = 1'b0;
      bus.ALU_OUT   = 16'hCAFE;
      bus.OUT_VALID = 1'b1;
      expQ.push_back(8'hFE);
      tick();
      applyStimulus(16'h1111, 1'b0);
      applyStimulus(16'h2222, 1'b0);
      bus.TX_READY = 1'b1;
      tick();
      checkOutput("rstMidSecondByte", {24'd0, bus.TX_DATA}, 32'hCA);
      checkOutput("rstMidFirstSent",  expQ.size(), 32'd0);
      doReset();
      checkOutput("rstMidValid", {31'd0, bus.TX_VALID}, 32'd0);
      checkOutput("rstMidBusy",  {31'd0, bus.BUSY}, 32'd0);
      checkOutput("rstMidFull",  {31'd0, bus.FIFO_FULL}, 32'd0);
      bus.TX_READY = 1'b1;
      applyStimulus(16'h0102, 1'b1);
      waitDrain("rstMidDrain");
      for (int i = 0; i < 5; i++) tick();
      checkOutput("rstMidQuiet", {31'd0, bus.TX_VALID}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
